// File: rtl/id_ex_pipeline_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_pipeline_reg
//  Description : ID/EX pipeline register of the 32-bit PA-RISC PPU. Carries
//                decoded operands, the raw 21-bit immediate, the operand-
//                handler select and the execute/memory controls from decode
//                into execute. Supports stall (hold), squash (flush) and a
//                per-entry valid bit.
//  Ports       : clk, reset (sync, active-high), hold, flush,
//                id_* inputs (valid, ra, rb, imm, soh_s, alu_op, rd, rf_le,
//                mem_en, mem_rw, mem_size, load, pc),
//                ex_* registered outputs (same set).
//  Options     : ID_EX_BUBBLE_CNT_EN adds output bubble_cnt[15:0], a
//                saturating count of bubbles loaded.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipeline_reg #(
    parameter int PC_W    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [31:0]        id_ra,
    input  logic [31:0]        id_rb,
    input  logic [20:0]        id_imm,
    input  logic [2:0]         id_soh_s,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic [4:0]         id_rd,
    input  logic               id_rf_le,
    input  logic               id_mem_en,
    input  logic               id_mem_rw,
    input  logic [1:0]         id_mem_size,
    input  logic               id_load,
    input  logic [PC_W-1:0]    id_pc,
    output logic               ex_valid,
    output logic [31:0]        ex_ra,
    output logic [31:0]        ex_rb,
    output logic [20:0]        ex_imm,
    output logic [2:0]         ex_soh_s,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [4:0]         ex_rd,
    output logic               ex_rf_le,
    output logic               ex_mem_en,
    output logic               ex_mem_rw,
    output logic [1:0]         ex_mem_size,
    output logic               ex_load,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [15:0]        bubble_cnt,
`endif
    output logic [PC_W-1:0]    ex_pc
);

    typedef struct packed {
        logic               valid;
        logic [31:0]        ra;
        logic [31:0]        rb;
        logic [20:0]        imm;
        logic [2:0]         soh_s;
        logic [ALUOP_W-1:0] alu_op;
        logic [4:0]         rd;
        logic               rf_le;
        logic               mem_en;
        logic               mem_rw;
        logic [1:0]         mem_size;
        logic               load;
        logic [PC_W-1:0]    pc;
    } entry_t;

    // A bubble is the all-zero entry, which is also the reset value.
    localparam entry_t C_BUBBLE = '0;

    entry_t entry_q;
    entry_t entry_d;
    entry_t id_entry;
    logic   bubble_load;

    assign id_entry = '{
        valid:    id_valid,
        ra:       id_ra,
        rb:       id_rb,
        imm:      id_imm,
        soh_s:    id_soh_s,
        alu_op:   id_alu_op,
        rd:       id_rd,
        rf_le:    id_rf_le,
        mem_en:   id_mem_en,
        mem_rw:   id_mem_rw,
        mem_size: id_mem_size,
        load:     id_load,
        pc:       id_pc
    };

    // Flush beats hold. An invalid decode slot loads a full bubble so that no
    // control bit can be set while the entry is invalid.
    always_comb begin
        entry_d     = entry_q;
        bubble_load = 1'b0;
        if (flush || (!hold && !id_valid)) begin
            entry_d     = C_BUBBLE;
            bubble_load = 1'b1;
        end else if (!hold) begin
            entry_d = id_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= C_BUBBLE;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign ex_valid    = entry_q.valid;
    assign ex_ra       = entry_q.ra;
    assign ex_rb       = entry_q.rb;
    assign ex_imm      = entry_q.imm;
    assign ex_soh_s    = entry_q.soh_s;
    assign ex_alu_op   = entry_q.alu_op;
    assign ex_rd       = entry_q.rd;
    assign ex_rf_le    = entry_q.rf_le;
    assign ex_mem_en   = entry_q.mem_en;
    assign ex_mem_rw   = entry_q.mem_rw;
    assign ex_mem_size = entry_q.mem_size;
    assign ex_load     = entry_q.load;
    assign ex_pc       = entry_q.pc;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q;
    logic [15:0] bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_load && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= 16'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    // Bubble indication only feeds the optional counter.
    logic unused_bubble_load;
    assign unused_bubble_load = bubble_load;
`endif

endmodule
`default_nettype wire
